// File: rtl/id_inst_queue.sv
// ----------------------------------------------------------------------------
// id_inst_queue
//   Instruction queue sitting between IF and ID. Holds up to DEPTH {pc, inst}
//   pairs, tracks the single one-cycle-latency fetch in flight to the
//   instruction SRAM, throttles IF so a returning fetch always has a free slot,
//   and drops everything (queued and in flight) on a branch redirect.
//
// Optional feature macro: ID_INST_QUEUE_BYPASS_EN
//   When defined, an empty queue forwards the returning SRAM data straight to
//   ID in the same cycle (1-cycle fetch-to-ID latency). When undefined, every
//   instruction passes through storage (2-cycle latency).
//
// Ports:
//   clk              in   rising-edge clock
//   resetn           in   asynchronous active-low reset
//   flush            in   branch redirect; drops queue and in-flight fetch
//   if_req           in   IF issues an SRAM fetch this cycle
//   if_pc            in   PC of the fetch issued this cycle
//   if_allow         out  IF may issue a fetch this cycle
//   inst_sram_rdata  in   SRAM data for the fetch accepted last cycle
//   id_ready         in   ID accepts the head entry this cycle
//   id_valid         out  head entry valid
//   id_pc            out  head PC (0 when id_valid=0)
//   id_inst          out  head instruction (0 when id_valid=0)
//   count            out  current occupancy
// ----------------------------------------------------------------------------
module id_inst_queue #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       if_req,
    input  logic [PC_W-1:0]            if_pc,
    output logic                       if_allow,
    input  logic [INST_W-1:0]          inst_sram_rdata,
    input  logic                       id_ready,
    output logic                       id_valid,
    output logic [PC_W-1:0]            id_pc,
    output logic [INST_W-1:0]          id_inst,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_cnt;
    logic              r_pend_v;
    logic [PC_W-1:0]   r_pend_pc;

    logic [PC_W-1:0]   r_mem_pc   [DEPTH];
    logic [INST_W-1:0] r_mem_inst [DEPTH];

    logic              w_q_nonempty;
    logic              w_byp;
    logic              w_byp_take;
    logic              w_fill;
    logic              w_pop;
    logic              w_accept;
    logic [CW:0]       w_occ;

    assign w_q_nonempty = (r_cnt != '0);

`ifdef ID_INST_QUEUE_BYPASS_EN
    // Empty queue with data returning this cycle: present it to ID directly.
    assign w_byp = ~w_q_nonempty & r_pend_v & ~flush;
`else
    assign w_byp = 1'b0;
`endif

    // Throttle counts the in-flight fetch as occupied, so it depends only on
    // registered state and flush, never on id_ready; a fill can never find
    // the queue full.
    assign w_occ      = {1'b0, r_cnt} + {{CW{1'b0}}, r_pend_v};
    assign if_allow   = flush | (w_occ < (CW+1)'(DEPTH));

    assign w_accept   = if_req & if_allow;
    assign w_byp_take = w_byp & id_ready;
    assign w_fill     = r_pend_v & ~flush & ~w_byp_take;
    assign w_pop      = w_q_nonempty & id_ready & ~flush;

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        id_valid = w_q_nonempty | w_byp;
        id_pc    = '0;
        id_inst  = '0;
        if (w_q_nonempty) begin
            id_pc   = r_mem_pc[r_rd_ptr];
            id_inst = r_mem_inst[r_rd_ptr];
        end else if (w_byp) begin
            id_pc   = r_pend_pc;
            id_inst = inst_sram_rdata;
        end
    end

    assign count = r_cnt;

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_cnt     <= '0;
            r_pend_v  <= 1'b0;
            r_pend_pc <= '0;
        end else begin
            // A fetch accepted in the flush cycle is the redirect target and
            // survives as the new in-flight entry.
            r_pend_v <= w_accept;
            if (w_accept) begin
                r_pend_pc <= if_pc;
            end

            if (flush) begin
                r_cnt    <= '0;
                r_rd_ptr <= r_wr_ptr;
            end else begin
                if (w_fill) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                case ({w_fill, w_pop})
                    2'b10:   r_cnt <= r_cnt + CW'(1);
                    2'b01:   r_cnt <= r_cnt - CW'(1);
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

    // NOTE: the data array carries no reset; validity lives entirely in the
    // pointers and count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_mem_pc[r_wr_ptr]   <= r_pend_pc;
            r_mem_inst[r_wr_ptr] <= inst_sram_rdata;
        end
    end

endmodule

// File: tb/tb_id_inst_queue.sv
// ----------------------------------------------------------------------------
// tb_id_inst_queue
//   Directed bench for id_inst_queue (DEPTH=4). A queue-based reference model
//   predicts every output each cycle; directed scenarios add hand-computed
//   literal expectations. Define ID_INST_QUEUE_BYPASS_EN to exercise the
//   bypass build.
// ----------------------------------------------------------------------------
module tb_id_inst_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] KEY = 32'hA5A5A5A5;
`ifdef ID_INST_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_pc = '0;
    logic        if_allow;
    logic [31:0] inst_sram_rdata = '0;
    logic        id_ready = 1'b0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [2:0]  count;

    id_inst_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .flush           (flush),
        .if_req          (if_req),
        .if_pc           (if_pc),
        .if_allow        (if_allow),
        .inst_sram_rdata (inst_sram_rdata),
        .id_ready        (id_ready),
        .id_valid        (id_valid),
        .id_pc           (id_pc),
        .id_inst         (id_inst),
        .count           (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] key(input logic [31:0] pc);
        return pc ^ KEY;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: an ordered list of {pc, inst} plus the in-flight fetch.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic        m_pend_v  = 1'b0;
    logic [31:0] m_pend_pc = '0;

    function automatic logic model_allow();
        return flush || ((mq.size() + int'(m_pend_v)) < DEPTH);
    endfunction

    function automatic logic model_bypass();
        return BYP && (mq.size() == 0) && m_pend_v && !flush;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mq.delete();
            m_pend_v  = 1'b0;
            m_pend_pc = '0;
        end else begin
            logic acc;
            logic byp;
            acc = if_req && model_allow();
            byp = model_bypass();
            if (flush) begin
                mq.delete();
            end else begin
                if (mq.size() > 0 && id_ready) void'(mq.pop_front());
                if (m_pend_v && !(byp && id_ready)) mq.push_back({m_pend_pc, key(m_pend_pc)});
            end
            m_pend_v = acc;
            if (acc) m_pend_pc = if_pc;
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        e_valid = (mq.size() > 0) || model_bypass();
        e_pc    = '0;
        e_inst  = '0;
        if (mq.size() > 0) begin
            e_pc   = mq[0].pc;
            e_inst = mq[0].inst;
        end else if (model_bypass()) begin
            e_pc   = m_pend_pc;
            e_inst = key(m_pend_pc);
        end
        check("cmp_if_allow", 64'(if_allow), 64'(model_allow()));
        check("cmp_id_valid", 64'(id_valid), 64'(e_valid));
        check("cmp_id_pc",    64'(id_pc),    64'(e_pc));
        check("cmp_id_inst",  64'(id_inst),  64'(e_inst));
        check("cmp_count",    64'(count),    64'(mq.size()));
    end

    // ------------------------------------------------------------------
    // Stimulus. Inputs change 1 time unit after the rising edge; the SRAM
    // returns key(pc) for the request presented in the previous cycle.
    // ------------------------------------------------------------------
    logic last_acc = 1'b0;

    task automatic tick();
        logic        req_q;
        logic [31:0] pc_q;
        #1;
        req_q    = if_req;
        pc_q     = if_pc;
        last_acc = if_req & if_allow;
        @(posedge clk);
        #1;
        inst_sram_rdata = req_q ? key(pc_q) : 32'h0BADF00D;
    endtask

    initial begin
        int n_acc;
        int guard;
        logic [31:0] pc;

        // 1. Reset then streaming
        tick();
        tick();
        check("rst_id_valid", 64'(id_valid), 64'd0);
        check("rst_id_pc",    64'(id_pc),    64'd0);
        check("rst_count",    64'(count),    64'd0);
        check("rst_if_allow", 64'(if_allow), 64'd1);
        resetn   = 1'b1;
        id_ready = 1'b1;
        pc = 32'hBFC00000;
        for (int i = 0; i < 8; i++) begin
            if_req = 1'b1;
            if_pc  = pc + 32'(4 * i);
            tick();
            if (i == (BYP ? 0 : 1)) begin
                check("stream_first_valid", 64'(id_valid), 64'd1);
                check("stream_first_pc",    64'(id_pc),    64'hBFC00000);
                check("stream_first_inst",  64'(id_inst),  64'h1A65A5A5);
            end
            check("stream_cnt_le1", 64'(count <= 3'd1), 64'd1);
            check("stream_allow",   64'(if_allow),      64'd1);
        end
        if_req = 1'b0;
        tick(); tick(); tick();
        check("stream_drained", 64'(count), 64'd0);
        id_ready = 1'b0;

        // 2. Fill to full
        for (int i = 0; i < 6; i++) begin
            if_req = 1'b1;
            if_pc  = 32'h00001000 + 32'(4 * i);
            tick();
            if (i == 3) check("full_allow_drop", 64'(if_allow), 64'd0);
        end
        if_req = 1'b0;
        #1;
        check("full_count",    64'(count),    64'd4);
        check("full_allow",    64'(if_allow), 64'd0);
        check("full_valid",    64'(id_valid), 64'd1);
        check("full_head_pc",  64'(id_pc),    64'h00001000);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        check("pop1_count",   64'(count),    64'd3);
        check("pop1_allow",   64'(if_allow), 64'd1);
        check("pop1_head_pc", 64'(id_pc),    64'h00001004);

        // 3. Flush with an in-flight fetch (cnt=3, pend_v=1)
        if_req = 1'b1;
        if_pc  = 32'h00002000;
        tick();
        check("pre_flush_allow", 64'(if_allow), 64'd0);
        flush  = 1'b1;
        if_pc  = 32'h80001000;
        tick();
        flush  = 1'b0;
        if_req = 1'b0;
        check("flush_count", 64'(count), 64'd0);
        tick();
        check("flush_valid", 64'(id_valid), 64'd1);
        check("flush_pc",    64'(id_pc),    64'h80001000);
        check("flush_inst",  64'(id_inst),  64'(key(32'h80001000)));
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        check("flush_drained", 64'(count), 64'd0);

        // 4. Wrap-around: 10 entries with alternating id_ready
        n_acc = 0;
        guard = 0;
        pc    = 32'h00003000;
        while (n_acc < 10 && guard < 40) begin
            if_req   = 1'b1;
            if_pc    = pc;
            id_ready = guard[0];
            tick();
            if (last_acc) begin
                n_acc++;
                pc = pc + 32'd4;
            end
            guard++;
        end
        check("wrap_accepted", 64'(n_acc), 64'd10);
        if_req   = 1'b0;
        id_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        id_ready = 1'b0;
        check("wrap_drained", 64'(count), 64'd0);

        // 5. Simultaneous fill and pop at cnt=2
        for (int i = 0; i < 3; i++) begin
            if_req = 1'b1;
            if_pc  = 32'h00004000 + 32'(4 * i);
            tick();
        end
        if_req = 1'b0;
        #1;
        check("sim_pre_count", 64'(count), 64'd2);
        check("sim_pre_pc",    64'(id_pc), 64'h00004000);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        check("sim_post_count", 64'(count), 64'd2);
        check("sim_post_pc",    64'(id_pc), 64'h00004004);

        // 6. Asynchronous reset mid-stream with cnt=3
        if_req = 1'b1;
        if_pc  = 32'h00005000;
        tick();
        if_req = 1'b0;
        tick();
        check("arst_pre_count", 64'(count), 64'd3);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_valid", 64'(id_valid), 64'd0);
        check("arst_count", 64'(count),    64'd0);
        check("arst_allow", 64'(if_allow), 64'd1);
        tick();
        resetn = 1'b1;
        if_req = 1'b1;
        if_pc  = 32'h00006000;
        tick();
        if_req = 1'b0;
        if (BYP) begin
            check("post_rst_valid_1c", 64'(id_valid), 64'd1);
            check("post_rst_pc_1c",    64'(id_pc),    64'h00006000);
        end else begin
            check("post_rst_valid_1c", 64'(id_valid), 64'd0);
            tick();
            check("post_rst_valid_2c", 64'(id_valid), 64'd1);
            check("post_rst_pc_2c",    64'(id_pc),    64'h00006000);
        end
        id_ready = 1'b1;
        tick();
        tick();
        check("final_count", 64'(count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_inst_queue.md
Name: id_inst_queue

Overview:
- Parametrised instruction queue between IF and ID. Replaces ID's single-entry stall buffer (one flag plus one captured instruction) with a DEPTH-entry FIFO of {pc, inst} pairs.
- Tracks the one-cycle-latency fetch in flight to instruction SRAM and throttles IF when the queue is full.
- Discards all queued and in-flight fetches on a branch redirect (flush).
- ID pops one instruction per cycle when not stalled.

Parameters:
- DEPTH, 4, number of queue entries; power of two, >= 2.
- PC_W, 32, PC width.
- INST_W, 32, instruction width.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- flush  in  1  branch redirect from ID (br_e); drops queue and in-flight fetch
- if_req  in  1  IF issues an SRAM fetch this cycle; data returns next cycle
- if_pc  in  PC_W  PC of the fetch issued this cycle
- if_allow  out  1  IF may issue a fetch this cycle
- inst_sram_rdata  in  INST_W  SRAM read data; valid the cycle after an accepted if_req
- id_ready  in  1  ID accepts the head entry this cycle (stall[1] == NoStop)
- id_valid  out  1  head entry valid
- id_pc  out  PC_W  head PC; 0 when id_valid=0
- id_inst  out  INST_W  head instruction; 0 when id_valid=0
- count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- State:
  - wr_ptr and rd_ptr, $clog2(DEPTH) bits each, wrap modulo DEPTH.
  - cnt.
  - pend_v / pend_pc: the single in-flight fetch.
- Reset: resetn low clears all state immediately (asynchronous). Resulting outputs: id_valid=0, id_pc=0, id_inst=0, count=0, if_allow=1. Reset mid-operation discards everything, including pend.
- Accept: an accepted fetch is if_req & if_allow.
  - On the next edge: pend_v<=1, pend_pc<=if_pc.
  - Otherwise pend_v<=0.
  - if_req while if_allow=0 is ignored (no state change).
- Fill: when pend_v=1 and flush=0, at the edge {pend_pc, inst_sram_rdata} is written at wr_ptr; wr_ptr++, cnt++.
- Pop: when id_valid & id_ready & ~flush, at the edge rd_ptr++, cnt--.
- Simultaneous fill and pop: cnt unchanged, both pointers advance. Reading and writing the same slot is legal, because the read takes the old contents.
- Throttle:
  - if_allow = flush | ((cnt + pend_v) < DEPTH).
  - if_allow is a function of registered state plus flush only; it has no combinational path from id_ready.
  - Because of this, a fill never meets a full queue.
- Full: cnt == DEPTH gives if_allow=0 (unless flush); id_valid=1.
- Empty: cnt == 0 gives id_valid=0 (except the bypass below); id_ready is ignored.
- Flush:
  - At the edge: cnt<=0, rd_ptr<=wr_ptr (or both to 0), pend_v<=0. The SRAM data arriving that cycle is discarded.
  - An if_req in the flush cycle is accepted and becomes the new pend (the redirect-target fetch).
  - A pop in the flush cycle has no additional effect.
  - The block does not track delay slots: ID asserts flush only after the delay-slot instruction has been popped.
- Latency, no bypass: if_req at cycle t, data is in the queue at t+2, id_valid at t+2.
- Storage: the data array is not reset; only the pointers and valid state are.

Optional Feature:
- Macro: ID_INST_QUEUE_BYPASS_EN.
- Defined:
  - When cnt==0 and pend_v=1 (and flush=0), id_valid=1, id_pc=pend_pc, id_inst=inst_sram_rdata, combinationally.
  - If id_ready is also 1, the entry is consumed directly: nothing is written and cnt stays 0.
  - If id_ready=0, the entry is written normally.
  - Latency from if_req to id_valid becomes 1 cycle.
- Undefined: no bypass; every instruction passes through storage with 2-cycle latency.
- if_allow is identical in both builds.

Test Plan:
1. Reset then streaming: resetn low then high; if_req=1 each cycle with pc 0xBFC00000, +4, ...; SRAM returns inst=pc^0xA5A5A5A5; id_ready=1 -> id_pc/id_inst sequence matches in order, count never exceeds 1, if_allow stays 1.
2. Fill to full (DEPTH=4): id_ready=0, if_req=1 continuously -> exactly 4 fetches accepted, if_allow drops to 0 once cnt+pend_v=4, count=4. Then id_ready=1 for 1 cycle -> head pops, if_allow=1 next cycle, no entry lost or duplicated.
3. Flush with in-flight fetch: cnt=3, pend_v=1, flush=1 with if_req=1, if_pc=0x80001000 -> next cycle count=0, old data discarded; following cycle id_valid=1, id_pc=0x80001000.
4. Wrap-around: push/pop 10 entries with alternating id_ready -> pointers wrap past DEPTH-1 and the output order is preserved.
5. Simultaneous fill and pop at cnt=2 -> count stays 2 and the head advances by one.
6. Asynchronous reset mid-stream: resetn low between clock edges with cnt=3 -> id_valid=0, count=0 immediately. With BYPASS_EN, the first fetch after reset shows id_valid one cycle after if_req.
